data_ram: RTL and testbench

Synthesizable-style responder for the CPU's data-side SRAM-like channel. It is the counterpart to the `mips` data master and sits beside `test_rom` in the testbench, so stores and loads execute against a real memory. It accepts one request per cycle and returns `data_ok` a fixed number of cycles later, in order. Optional pseudo-random `addr_ok` stalls stress the CPU's handshake logic.

---
 rtl/sram_like_pkg.sv | 40 ++++
 rtl/data_ram_stall.sv | 27 ++
 rtl/data_ram.sv | 135 +++++++++++++
 tb/tb_data_ram.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared types and helpers for the SRAM-like data channel.
//   size_e      - transfer size encodings (byte / half / word; 3 aliases word)
//   sram_req_t  - one in-flight request: {wr, word index, wdata, byte enable}
//   size_to_be  - byte-enable generation, zero for misaligned accesses
package sram_like_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } size_e;

    // Full word-index width of a 32-bit byte address; the RAM keeps the low bits.
    localparam int unsigned INDEX_W = 30;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef struct packed {
        logic               wr;
        logic [INDEX_W-1:0] index;
        logic [31:0]        wdata;
        logic [3:0]         be;
    } sram_req_t;

    function automatic logic [3:0] size_to_be(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] be;
        be = '0;
        case (size_e'(size))
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[0] ? 4'b0000 : (4'b0011 << addr_lo);
            default: be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_ram_stall.sv
// stall_lfsr: free-running 8-bit Fibonacci LFSR used to withhold addr_ok.
//   clk      in  : clock
//   rst      in  : asynchronous active-low reset, reseeds the LFSR
//   stall    out : high when STALL_EN is set and the two LSBs are zero
module stall_lfsr
    import sram_like_pkg::*;
#(
    parameter int unsigned STALL_EN = 0
) (
    input  logic clk,
    input  logic rst,
    output logic stall
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign stall = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/data_ram.sv
// data_ram: responder for the CPU data-side SRAM-like channel.
// Accepts one request per cycle and completes it LATENCY cycles later, in order.
//   clk           in  : clock
//   rst           in  : asynchronous active-low reset (ram contents retained)
//   data_req      in  : request valid
//   data_wr       in  : 1 = store, 0 = load
//   data_size     in  : 0 byte, 1 half, 2/3 word
//   data_addr     in  : byte address (upper bits alias)
//   data_wdata    in  : lane-aligned store data
//   data_rdata    out : loaded word while data_data_ok, else 0
//   data_addr_ok  out : request accepted on req && addr_ok at a rising edge
//   data_data_ok  out : one-cycle completion pulse
module data_ram
    import sram_like_pkg::*;
#(
    parameter int unsigned ADDR_BITS       = 12,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STALL_EN        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    logic [31:0] ram [2**ADDR_BITS];

    logic                 stall;
    logic                 accept;
    logic [3:0]           count_q;
    logic [3:0]           live;
    logic                 data_ok_q;
    logic [31:0]          rdata_q;
    sram_req_t            in_req;
    sram_req_t            head;
    logic                 head_v;
    logic [ADDR_BITS-1:0] head_idx;
    logic                 unused_index;

    stall_lfsr #(
        .STALL_EN (STALL_EN)
    ) u_stall (
        .clk   (clk),
        .rst   (rst),
        .stall (stall)
    );

    // The entry whose data_ok is showing this cycle retires at the coming edge,
    // so its slot can be reused by a request accepted on that same edge.
    assign live         = count_q - {3'b000, data_ok_q};
    assign data_addr_ok = rst && !stall && (live < 4'(MAX_OUTSTANDING));
    assign accept       = data_req && data_addr_ok;

    always_comb begin
        in_req       = '0;
        in_req.wr    = data_wr;
        in_req.index = data_addr[31:2];
        in_req.wdata = data_wdata;
        in_req.be    = size_to_be(data_size, data_addr[1:0]);
    end

    // head is the entry completing at the next edge: LATENCY-1 register stages
    // after acceptance; with LATENCY==1 the incoming request completes directly.
    generate
        if (LATENCY == 1) begin : g_direct
            assign head   = in_req;
            assign head_v = accept;
        end else begin : g_pipe
            sram_req_t          pipe_q [LATENCY-1];
            logic [LATENCY-2:0] pipe_v;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= accept;
                    for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipe_q[0] <= in_req;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign head   = pipe_q[LATENCY-2];
            assign head_v = pipe_v[LATENCY-2];
        end
    endgenerate

    assign head_idx     = head.index[ADDR_BITS-1:0];
    assign unused_index = ^head.index[INDEX_W-1:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (head_v && head.wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (head.be[b]) begin
                    ram[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            count_q   <= '0;
        end else begin
            data_ok_q <= head_v;
            rdata_q   <= (head_v && !head.wr) ? ram[head_idx] : '0;
            count_q   <= count_q + {3'b000, accept} - {3'b000, data_ok_q};
        end
    end

    assign data_rdata   = rdata_q;
    assign data_data_ok = data_ok_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= 4'(MAX_OUTSTANDING));
    a_ok_needs_count: assert property (@(posedge clk) disable iff (!rst)
        data_ok_q |-> (count_q != '0));

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: three data_ram instances (LAT2/MAX2, LAT4/MAX2, LAT1/MAX1 with
// stalls) driven by directed tables, hand sequences and random traffic, and
// checked every cycle against a transaction-level memory model.
module tb_data_ram;

    localparam int NCFG = 3;
    localparam int unsigned LAT_C [NCFG] = '{2, 4, 1};
    localparam int unsigned MAX_C [NCFG] = '{2, 2, 1};
    localparam int unsigned STL_C [NCFG] = '{0, 0, 1};

    logic        clk;
    logic        rst_v   [NCFG];
    logic        req_v   [NCFG];
    logic        wr_v    [NCFG];
    logic [1:0]  size_v  [NCFG];
    logic [31:0] addr_v  [NCFG];
    logic [31:0] wdata_v [NCFG];
    logic [31:0] rdata_v [NCFG];
    logic        aok_v   [NCFG];
    logic        dok_v   [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        data_ram #(
            .ADDR_BITS       (12),
            .LATENCY         (LAT_C[g]),
            .MAX_OUTSTANDING (MAX_C[g]),
            .STALL_EN        (STL_C[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst_v[g]),
            .data_req     (req_v[g]),
            .data_wr      (wr_v[g]),
            .data_size    (size_v[g]),
            .data_addr    (addr_v[g]),
            .data_wdata   (wdata_v[g]),
            .data_rdata   (rdata_v[g]),
            .data_addr_ok (aok_v[g]),
            .data_data_ok (dok_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } pend_t;

    pend_t       pend    [NCFG][16];
    int          p_head  [NCFG];
    int          p_cnt   [NCFG];
    logic [31:0] mmem    [NCFG][16];
    logic [7:0]  mlfsr   [NCFG];
    int          edge_no [NCFG];
    logic        exp_aok [NCFG];

    int n_checks;
    int n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic model_store(input int c, input pend_t p);
        int lo;
        lo = int'(p.addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            bit en;
            case (p.size)
                2'd0:    en = (b == lo);
                2'd1:    en = (lo % 2 == 0) && (b == lo || b == lo + 1);
                default: en = (lo == 0);
            endcase
            if (en) mmem[c][p.addr[5:2]][8*b +: 8] = p.wdata[8*b +: 8];
        end
    endtask

    // Advance one clock for config c and check its outputs against the model.
    task automatic step(input int c);
        logic        exp_dok;
        logic [31:0] exp_rd;
        pend_t       p;
        @(negedge clk);
        edge_no[c]++;
        exp_dok = 1'b0;
        exp_rd  = '0;
        if (!rst_v[c]) begin
            p_cnt[c]  = 0;
            p_head[c] = 0;
            mlfsr[c]  = 8'hA5;
        end else begin
            if (req_v[c] && exp_aok[c]) begin
                pend[c][(p_head[c] + p_cnt[c]) % 16] =
                    '{wr_v[c], size_v[c], addr_v[c], wdata_v[c], edge_no[c] + int'(LAT_C[c]) - 1};
                p_cnt[c]++;
            end
            mlfsr[c] = {mlfsr[c][6:0], mlfsr[c][7] ^ mlfsr[c][5] ^ mlfsr[c][4] ^ mlfsr[c][3]};
            if (p_cnt[c] > 0 && pend[c][p_head[c]].due == edge_no[c]) begin
                p = pend[c][p_head[c]];
                p_head[c] = (p_head[c] + 1) % 16;
                p_cnt[c]--;
                exp_dok = 1'b1;
                if (p.wr) model_store(c, p);
                else      exp_rd = mmem[c][p.addr[5:2]];
            end
        end
        exp_aok[c] = rst_v[c] && (p_cnt[c] < int'(MAX_C[c])) &&
                     !(STL_C[c] != 0 && mlfsr[c][1:0] == 2'b00);
        chk($sformatf("c%0d data_ok @%0d", c, edge_no[c]), 32'(dok_v[c]), 32'(exp_dok));
        chk($sformatf("c%0d addr_ok @%0d", c, edge_no[c]), 32'(aok_v[c]), 32'(exp_aok[c]));
        if (exp_dok || !rst_v[c])
            chk($sformatf("c%0d rdata @%0d", c, edge_no[c]), rdata_v[c], exp_rd);
    endtask

    // One request: hold until accepted, then wait for its data_ok.
    task automatic do_txn(input int c, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int   n;
        logic acc;
        req_v[c] = 1'b1; wr_v[c] = wr; size_v[c] = sz; addr_v[c] = a; wdata_v[c] = wd;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = aok_v[c];
            step(c);
            n++;
        end
        req_v[c] = 1'b0;
        chk($sformatf("c%0d accept within bound", c), 32'(acc), 32'd1);
        lat = 0;
        while (!dok_v[c] && lat < 20) begin
            step(c);
            lat++;
        end
        rd = rdata_v[c];
        chk($sformatf("c%0d txn latency", c), 32'(lat), 32'(LAT_C[c] - 1));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic directed_c0();
        vec_t        vt [14];
        logic [31:0] rd;
        int          lat;
        logic        acc1, acc2;
        int          nd, first_k, last_k;
        logic [31:0] last_rd;
        vt[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'h1234_5678, 32'h0};
        vt[1]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'h1234_5678};
        vt[2]  = '{1'b1, 2'd0, 32'h0000_0011, 32'h0000_AB00, 32'h0};
        vt[3]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'h1234_AB78};
        vt[4]  = '{1'b1, 2'd2, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0};
        vt[5]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'h1234_AB78};
        vt[6]  = '{1'b0, 2'd2, 32'h0000_4010, 32'h0,         32'h1234_AB78};
        vt[7]  = '{1'b1, 2'd1, 32'h0000_4012, 32'hCAFE_0000, 32'h0};
        vt[8]  = '{1'b0, 2'd0, 32'h0000_0010, 32'h0,         32'hCAFE_AB78};
        vt[9]  = '{1'b1, 2'd3, 32'h0000_0013, 32'h1100_0000, 32'h0};
        vt[10] = '{1'b1, 2'd0, 32'h0000_0013, 32'h5500_0000, 32'h0};
        vt[11] = '{1'b1, 2'd1, 32'h0000_0011, 32'h00FF_FF00, 32'h0};
        vt[12] = '{1'b0, 2'd1, 32'h0000_0012, 32'h0,         32'h55FE_AB78};
        vt[13] = '{1'b0, 2'd2, 32'hFFFF_C010, 32'h0,         32'h55FE_AB78};
        for (int i = 0; i < 14; i++) begin
            do_txn(0, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, rd, lat);
            chk($sformatf("c0 vec%0d rdata", i), rd, vt[i].exp_rd);
        end
        step(0);

        // back-to-back store then load of the same word
        req_v[0] = 1'b1; wr_v[0] = 1'b1; size_v[0] = 2'd2; addr_v[0] = 32'h20; wdata_v[0] = 32'hA5A5_0001;
        acc1 = aok_v[0];
        step(0);
        wr_v[0] = 1'b0;
        acc2 = aok_v[0];
        step(0);
        req_v[0] = 1'b0;
        chk("c0 b2b accept store", 32'(acc1), 32'd1);
        chk("c0 b2b accept load", 32'(acc2), 32'd1);
        nd = 0; first_k = -1; last_k = -1; last_rd = '0;
        for (int k = 0; k < 6; k++) begin
            if (dok_v[0]) begin
                nd++;
                if (first_k < 0) first_k = k;
                last_k  = k;
                last_rd = rdata_v[0];
            end
            step(0);
        end
        chk("c0 b2b data_ok count", 32'(nd), 32'd2);
        chk("c0 b2b pulses adjacent", 32'(last_k - first_k), 32'd1);
        chk("c0 b2b load data", last_rd, 32'hA5A5_0001);

        // reset one cycle after accept: request dropped, ram retained
        req_v[0] = 1'b1; wr_v[0] = 1'b0; size_v[0] = 2'd2; addr_v[0] = 32'h10;
        acc1 = aok_v[0];
        step(0);
        req_v[0] = 1'b0;
        chk("c0 rst accept", 32'(acc1), 32'd1);
        rst_v[0] = 1'b0;
        #1;
        chk("c0 async rst addr_ok", 32'(aok_v[0]), 32'd0);
        chk("c0 async rst data_ok", 32'(dok_v[0]), 32'd0);
        chk("c0 async rst rdata", rdata_v[0], 32'd0);
        repeat (3) step(0);
        rst_v[0] = 1'b1;
        step(0);
        do_txn(0, 1'b0, 2'd2, 32'h10, 32'h0, rd, lat);
        chk("c0 ram retained over reset", rd, 32'h55FE_AB78);
    endtask

    task automatic directed_c1();
        logic pat_aok [10];
        logic pat_dok [10];
        pat_aok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pat_dok = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        step(1);
        req_v[1] = 1'b1; wr_v[1] = 1'b0; size_v[1] = 2'd2; addr_v[1] = 32'h0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("c1 backpressure addr_ok k%0d", k), 32'(aok_v[1]), 32'(pat_aok[k]));
            chk($sformatf("c1 backpressure data_ok k%0d", k), 32'(dok_v[1]), 32'(pat_dok[k]));
            step(1);
        end
        req_v[1] = 1'b0;
        repeat (6) step(1);
    endtask

    task automatic directed_c2();
        int   hi;
        int   n_acc, n_dok, run, max_run;
        logic prev_acc, acc;
        step(2);
        hi = 0;
        for (int k = 0; k < 1000; k++) begin
            if (aok_v[2]) hi++;
            step(2);
        end
        chk("c2 stall duty 700..800", 32'(hi >= 700 && hi <= 800), 32'd1);

        n_acc = 0; n_dok = 0; run = 0; max_run = 0; prev_acc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            req_v[2] = 1'b1; wr_v[2] = 1'b1; size_v[2] = 2'd2;
            addr_v[2] = {$urandom() & 32'hFFFF_C000} | 32'($urandom_range(0, 15) << 2);
            wdata_v[2] = $urandom();
            chk($sformatf("c2 data_ok follows accept k%0d", k), 32'(dok_v[2]), 32'(prev_acc));
            if (dok_v[2]) n_dok++;
            acc = aok_v[2];
            if (acc) begin n_acc++; run++; end
            else run = 0;
            if (run > max_run) max_run = run;
            prev_acc = acc;
            step(2);
        end
        req_v[2] = 1'b0;
        if (dok_v[2]) n_dok++;
        chk("c2 last data_ok", 32'(dok_v[2]), 32'(prev_acc));
        chk("c2 accepts == completions", 32'(n_dok), 32'(n_acc));
        chk("c2 back-to-back accepts seen", 32'(max_run >= 2), 32'd1);
        step(2);
    endtask

    task automatic run_cfg(input int c);
        logic [31:0] rd;
        int          lat;
        repeat (3) step(c);
        rst_v[c] = 1'b1;
        step(c);
        for (int i = 0; i < 16; i++) do_txn(c, 1'b1, 2'd2, 32'(i * 4), $urandom(), rd, lat);
        case (c)
            0:       directed_c0();
            1:       directed_c1();
            default: directed_c2();
        endcase
        for (int k = 0; k < 400; k++) begin
            req_v[c]   = ($urandom_range(0, 3) != 0);
            wr_v[c]    = $urandom_range(0, 1) != 0;
            size_v[c]  = 2'($urandom_range(0, 3));
            addr_v[c]  = rand_addr();
            wdata_v[c] = $urandom();
            step(c);
        end
        req_v[c] = 1'b0;
        repeat (12) step(c);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int c = 0; c < NCFG; c++) begin
            rst_v[c] = 1'b1; req_v[c] = 1'b0; wr_v[c] = 1'b0; size_v[c] = 2'd0;
            addr_v[c] = '0; wdata_v[c] = '0;
            p_head[c] = 0; p_cnt[c] = 0; mlfsr[c] = 8'hA5; edge_no[c] = 0; exp_aok[c] = 1'b0;
            for (int i = 0; i < 16; i++) mmem[c][i] = '0;
        end
        #2;
        for (int c = 0; c < NCFG; c++) rst_v[c] = 1'b0;
        fork
            run_cfg(0);
            run_cfg(1);
            run_cfg(2);
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
